snake_motion_engine: RTL and testbench

- Consumer of the button controller's outputs: takes the 2-bit move direction and pause level, advances the snake one grid cell per step tick.
- Holds the body as a segment shift register, handles growth requests and wall/self collision, and raises game-over.
- Feeds the video/render block (segment query port) and the food/score logic (head position, length, step strobe).

---
 rtl/snake_motion_if.sv | 34 +++
 rtl/snake_motion_engine.sv | 154 +++++++++++++++
 tb/tb_snake_motion_engine.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/snake_motion_if.sv
// Control, render-query and status signals between the snake
// motion engine and the logic that drives and observes it.
interface snake_motion_if #(
    parameter int X_W   = 6,
    parameter int Y_W   = 5,
    parameter int LEN_W = 5
);
    logic [1:0]       move_state;
    logic             is_paused;
    logic             grow_req;
    logic             restart;
    logic [X_W-1:0]   query_x;
    logic [Y_W-1:0]   query_y;
    logic             query_hit;
    logic [X_W-1:0]   head_x;
    logic [Y_W-1:0]   head_y;
    logic [LEN_W-1:0] snake_len;
    logic             step_pulse;
    logic             game_over;

    modport master (
        output move_state, is_paused, grow_req, restart,
        output query_x, query_y,
        input  query_hit, head_x, head_y, snake_len,
        input  step_pulse, game_over
    );

    modport slave (
        input  move_state, is_paused, grow_req, restart,
        input  query_x, query_y,
        output query_hit, head_x, head_y, snake_len,
        output step_pulse, game_over
    );
endinterface

// File: rtl/snake_motion_engine.sv
// Snake body shift register, step timing, growth and
// wall/self collision with a RUN/PAUSED/OVER state machine.
module snake_motion_engine #(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int X_W      = 6,
    parameter int Y_W      = 5,
    parameter int MAX_LEN  = 16,
    parameter int LEN_W    = 5,
    parameter int INIT_LEN = 3,
    parameter int STEP_DIV = 5000000
) (
    input  logic           clk,
    input  logic           rst_n,
    snake_motion_if.slave  bus
);
    typedef enum logic [1:0] {RUN, PAUSED, OVER} state_t;

    localparam logic [1:0] UP    = 2'd0;
    localparam logic [1:0] DOWN  = 2'd1;
    localparam logic [1:0] LEFT  = 2'd2;
    localparam logic [1:0] RIGHT = 2'd3;

    localparam int CNT_W = $clog2(STEP_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [X_W:0]     X_ONE    = (X_W+1)'(1);
    localparam logic [Y_W:0]     Y_ONE    = (Y_W+1)'(1);
    localparam logic [X_W:0]     X_LIM    = (X_W+1)'(GRID_W);
    localparam logic [Y_W:0]     Y_LIM    = (Y_W+1)'(GRID_H);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(INIT_LEN);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       cur_dir, next_dir;
    logic [X_W-1:0]   seg_x [MAX_LEN];
    logic [Y_W-1:0]   seg_y [MAX_LEN];
    logic [LEN_W-1:0] len;
    logic             grow_pending;
    logic             step_pulse_q;
    logic [X_W:0]     nx;
    logic [Y_W:0]     ny;
    logic             step, growing, wall, self_hit;
    logic             collide, move, do_init, hit;

    assign step    = (state == RUN) && !bus.is_paused && (cnt == CNT_LAST);
    assign do_init = !rst_n || ((state == OVER) && bus.restart);
    assign growing = (grow_pending || bus.grow_req) && (len < LEN_MAX);
    assign wall    = (nx >= X_LIM) || (ny >= Y_LIM);
    assign collide = step && (wall || self_hit);
    assign move    = step && !collide;

    // Direction for this step, refusing a direct reversal.
    always_comb begin
        next_dir = bus.move_state;
        if (bus.move_state == (cur_dir ^ 2'b01)) next_dir = cur_dir;
    end

    // Candidate head one bit wider so underflow/overflow is visible.
    always_comb begin
        nx = {1'b0, seg_x[0]};
        ny = {1'b0, seg_y[0]};
        unique case (next_dir)
            UP:    ny = ny - Y_ONE;
            DOWN:  ny = ny + Y_ONE;
            LEFT:  nx = nx - X_ONE;
            RIGHT: nx = nx + X_ONE;
        endcase
    end

    // Body overlap; the tail leaves this step unless the snake grows.
    always_comb begin
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < len) &&
                (seg_x[i] == nx[X_W-1:0]) &&
                (seg_y[i] == ny[Y_W-1:0]) &&
                (growing || (LEN_W'(i) != len - LEN_ONE)))
                self_hit = 1'b1;
        end
    end

    // Render query against live segments only.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < len) &&
                (seg_x[i] == bus.query_x) &&
                (seg_y[i] == bus.query_y))
                hit = 1'b1;
        end
    end

    // Game state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // Game state transitions.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (bus.is_paused) state_nxt = PAUSED;
                else if (collide)  state_nxt = OVER;
            end
            PAUSED: if (!bus.is_paused) state_nxt = RUN;
            OVER:   if (bus.restart)    state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Step timer, body shift, growth and step strobe.
    always_ff @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= (i < INIT_LEN) ? X_W'(GRID_W / 2 - i) : '0;
                seg_y[i] <= (i < INIT_LEN) ? Y_W'(GRID_H / 2) : '0;
            end
            len          <= LEN_INIT;
            cur_dir      <= RIGHT;
            cnt          <= '0;
            grow_pending <= 1'b0;
            step_pulse_q <= 1'b0;
        end else begin
            step_pulse_q <= move;
            if ((state == RUN) && !bus.is_paused)
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_ONE;
            if (move) begin
                cur_dir <= next_dir;
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
                seg_x[0]     <= nx[X_W-1:0];
                seg_y[0]     <= ny[Y_W-1:0];
                grow_pending <= 1'b0;
                if (growing) len <= len + LEN_ONE;
            end else if (bus.grow_req && (state != OVER)) begin
                grow_pending <= 1'b1;
            end
        end
    end

    assign bus.query_hit  = hit;
    assign bus.head_x     = seg_x[0];
    assign bus.head_y     = seg_y[0];
    assign bus.snake_len  = len;
    assign bus.step_pulse = step_pulse_q;
    assign bus.game_over  = (state == OVER);
endmodule

// File: tb/tb_snake_motion_engine.sv
// Directed bench for snake_motion_engine with STEP_DIV=4; each
// expected step result is queued and checked on step_pulse.
module tb_snake_motion_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q [$];
    logic [15:0] exp_e;
    logic [15:0] got_e;

    always #5 clk = ~clk;

    snake_motion_if #(.X_W(6), .Y_W(5), .LEN_W(5)) bus ();

    snake_motion_engine #(.STEP_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Scoreboard monitor: every step strobe must match a queued move.
    always @(negedge clk) begin
        if (rst_n && bus.step_pulse) begin
            checks++;
            got_e = {bus.head_x, bus.head_y, bus.snake_len};
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_step actual x=%0d y=%0d len=%0d required none",
                         bus.head_x, bus.head_y, bus.snake_len);
            end else begin
                exp_e = exp_q.pop_front();
                if (got_e !== exp_e)
                begin
                    failures++;
                    $display("FAIL step_result actual x=%0d y=%0d len=%0d required x=%0d y=%0d len=%0d",
                             got_e[15:10], got_e[9:5], got_e[4:0],
                             exp_e[15:10], exp_e[9:5], exp_e[4:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input int x, input int y, input int l);
        exp_q.push_back({6'(x), 5'(y), 5'(l)});
    endtask

    task automatic q(input int x, input int y, input int req);
        bus.query_x = 6'(x);
        bus.query_y = 5'(y);
        #1;
        chk($sformatf("query_%0d_%0d", x, y), int'(bus.query_hit), req);
    endtask

    task automatic wait_pulse(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.step_pulse && n < 40);
        chk({name, "_step_seen"}, int'(bus.step_pulse), 1);
    endtask

    task automatic wait_over(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.game_over && n < 40);
        chk({name, "_game_over"}, int'(bus.game_over), 1);
    endtask

    task automatic mv(input int d, input int x, input int y,
                      input int l, input int g);
        bus.move_state = 2'(d);
        push(x, y, l);
        for (int k = 0; k < g; k++) begin
            bus.grow_req = 1'b1;
            tick();
            bus.grow_req = 1'b0;
            if (k < g - 1) tick();
        end
        wait_pulse("move");
    endtask

    task automatic do_restart();
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        chk("restart_head_x", int'(bus.head_x), 20);
        chk("restart_head_y", int'(bus.head_y), 15);
        chk("restart_len", int'(bus.snake_len), 3);
        chk("restart_over", int'(bus.game_over), 0);
    endtask

    initial begin
        int bad;
        bus.move_state = 2'd3;
        bus.is_paused  = 1'b0;
        bus.grow_req   = 1'b0;
        bus.restart    = 1'b0;
        bus.query_x    = '0;
        bus.query_y    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_head_x", int'(bus.head_x), 20);
        chk("rst_head_y", int'(bus.head_y), 15);
        chk("rst_len", int'(bus.snake_len), 3);
        chk("rst_over", int'(bus.game_over), 0);
        chk("rst_pulse", int'(bus.step_pulse), 0);
        q(20, 15, 1);
        q(18, 15, 1);
        q(17, 15, 0);
        rst_n = 1'b1;

        push(21, 15, 3);
        repeat (3) tick();
        chk("pre_step_pulse", int'(bus.step_pulse), 0);
        chk("pre_step_head_x", int'(bus.head_x), 20);
        tick();
        chk("first_step_pulse", int'(bus.step_pulse), 1);
        q(19, 15, 1);
        q(18, 15, 0);
        tick();
        chk("pulse_one_cycle", int'(bus.step_pulse), 0);

        mv(2, 22, 15, 3, 0);
        mv(0, 22, 14, 3, 0);

        bus.move_state = 2'd2;
        push(21, 14, 3);
        tick();
        tick();
        bus.is_paused = 1'b1;
        bad = 0;
        repeat (20) begin
            tick();
            if (bus.step_pulse || bus.head_x != 22 || bus.head_y != 14)
                bad = 1;
        end
        chk("pause_frozen", bad, 0);
        bus.is_paused = 1'b0;
        tick();
        tick();
        chk("resume_early_pulse", int'(bus.step_pulse), 0);
        tick();
        chk("resume_step_pulse", int'(bus.step_pulse), 1);

        mv(2, 20, 14, 4, 1);
        q(22, 15, 1);
        mv(1, 20, 15, 4, 0);
        mv(3, 21, 15, 4, 0);
        mv(0, 21, 14, 4, 0);
        chk("tail_chase_no_over", int'(bus.game_over), 0);

        mv(0, 21, 13, 5, 2);
        mv(3, 22, 13, 5, 0);
        mv(1, 22, 14, 5, 0);
        bus.move_state = 2'd2;
        wait_over("self");
        chk("self_head_x", int'(bus.head_x), 22);
        chk("self_head_y", int'(bus.head_y), 14);
        chk("self_len", int'(bus.snake_len), 5);
        bus.grow_req = 1'b1;
        tick();
        bus.grow_req = 1'b0;
        tick();
        chk("over_holds", int'(bus.game_over), 1);
        do_restart();
        q(18, 15, 1);
        q(21, 14, 0);

        for (int k = 1; k <= 14; k++)
            mv(3, 20 + k, 15, (3 + k > 16) ? 16 : 3 + k, 1);
        for (int x = 35; x <= 39; x++)
            mv(3, x, 15, 16, 0);
        q(24, 15, 1);
        q(23, 15, 0);
        bus.move_state = 2'd3;
        wait_over("wall_right");
        chk("wall_right_head_x", int'(bus.head_x), 39);
        chk("wall_right_len", int'(bus.snake_len), 16);
        do_restart();

        for (int y = 14; y >= 0; y--)
            mv(0, 20, y, 3, 0);
        bus.move_state = 2'd0;
        wait_over("wall_up");
        chk("wall_up_head_x", int'(bus.head_x), 20);
        chk("wall_up_head_y", int'(bus.head_y), 0);
        chk("wall_up_len", int'(bus.snake_len), 3);
        do_restart();

        repeat (2) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
